prf_multiport: RTL and testbench
================================

Name: prf_multiport

Overview:
- Parametrised physical register file for the out-of-order RV32I backend.
- Generalises the fixed 5-pair, single-write-port file:
  - configurable read-pair count (one pair per functional unit);
  - configurable write-back port count;
  - per-register ready (scoreboard) bits, set by writeback and cleared by rename allocation;
  - optional same-cycle write-to-read bypass.
- Sits between rename/dispatch (allocation), reservation stations (ready query, operand read) and the CDB writeback ports.

Parameters:
- PREG_W, 6, physical register index width.
- NUM_PREGS, 64, number of physical registers; must equal 2**PREG_W.
- NUM_RD, 5, number of read-port pairs (ps1/ps2 per functional unit).
- NUM_WR, 2, number of writeback ports.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  mispredict recovery; sets every ready bit to 1.
- alloc_valid  in  1  rename allocates a destination this cycle.
- alloc_pd  in  PREG_W  allocated physical register.
- wr_en  in  NUM_WR  per-port writeback enable.
- wr_pd  in  NUM_WR*PREG_W  per-port destination index.
- wr_data  in  NUM_WR*32  per-port writeback value.
- rd_ps1  in  NUM_RD*PREG_W  source-1 index per channel.
- rd_ps2  in  NUM_RD*PREG_W  source-2 index per channel.
- rd_v1  out  NUM_RD*32  source-1 value per channel.
- rd_v2  out  NUM_RD*32  source-2 value per channel.
- rdy1  out  NUM_RD  source-1 ready per channel.
- rdy2  out  NUM_RD  source-2 ready per channel.
- wr_conflict  out  1  registered flag: two enabled write ports targeted the same nonzero preg in the previous cycle.

Behaviour:
- Reset (rst_n=0 at posedge):
  - all data entries 0; all ready bits 1; wr_conflict 0.
  - While rst_n=0, all rd_v* read 0 and all rdy* read 1.
- Preg 0 is hardwired:
  - reads always return 0 with ready 1;
  - writes to preg 0 are dropped;
  - allocation of preg 0 is ignored.
- Write:
  - at posedge, for each port k with wr_en[k] && wr_pd[k]!=0: data[wr_pd[k]] <= wr_data[k] and ready[wr_pd[k]] <= 1.
  - If several ports hit the same nonzero preg in one cycle, the highest port index wins, and wr_conflict is 1 in the next cycle.
- Allocate:
  - at posedge, alloc_valid && alloc_pd!=0 sets ready[alloc_pd] <= 0.
  - Allocate and write to the same preg in one cycle: allocate wins, so ready ends at 0 and data takes the written value.
- Flush:
  - at posedge, all ready bits <= 1; data is unchanged.
  - flush overrides a same-cycle alloc_valid; same-cycle writes still commit.
  - Reset overrides flush.
- Read ports are combinational (zero latency) and independent per channel.
  - Any index may be read on any number of channels simultaneously.
- Ready outputs are combinational from the ready array, with the same bypass rule as data when bypass is enabled.
- Timing: a write at edge N is visible without bypass from cycle N+1; an allocation at edge N shows rdy=0 from cycle N+1.

Optional Feature:
- Macro: PRF_WR_BYPASS_EN.
- Defined: a read whose index matches an enabled nonzero same-cycle write returns wr_data (highest matching port) and rdy=1, in the same cycle.
  - Allocation does not bypass into rdy.
- Undefined: reads return array contents only; the write becomes visible the cycle after.

Decomposition:
- Shared package rv32i_types holds:
  - the functional-unit channel enum (alu, mem, div, mul, br), used to index read channels;
  - the preg index typedef of width PREG_W;
  - a localparam NUM_FU=5.
- One sub-module, prf_wr_arbiter: combinational highest-index-wins merge of the write ports. It produces per-preg write enable and data plus the conflict detect; the top instantiates it once.
- The storage array, ready array and read muxes stay in prf_multiport.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then release -> every preg reads 0 and every rdy reads 1; wr_conflict=0.
- Allocate then write back:
  - alloc preg 12 at cycle 1 -> rdy1=0 on a channel reading 12 from cycle 2;
  - port 1 writes 0xDEADBEEF to 12 at cycle 4 -> from cycle 5, rd_v1=0xDEADBEEF and rdy1=1 on all 5 channels.
- Dual write conflict: ports 0 and 1 write 0x11 and 0x22 to preg 7 in the same cycle -> preg 7 holds 0x22; wr_conflict=1 for exactly one cycle.
- Preg 0: write 0x55 to preg 0 and allocate preg 0 -> reads still 0, rdy 1; wr_conflict stays 0 even when both ports hit preg 0.
- Bypass:
  - with PRF_WR_BYPASS_EN: port 0 writes 0xA5A5 to preg 30 while channel mul reads 30 -> same-cycle rd_v=0xA5A5, rdy=1;
  - without the macro: old value 0 in that cycle, 0xA5A5 the next cycle.
- Flush and collisions:
  - alloc pregs 3, 4, 5, then flush with alloc 9 in the same cycle -> all rdy=1, including preg 9;
  - alloc 40 and write 0x7 to 40 in the same cycle -> rdy=0, value 0x7.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the RV32I out-of-order backend.
//   fu_e   : functional-unit channel, used to index the read-port pairs
//   preg_t : physical register index
//   NUM_FU : number of functional units (one read pair each)
package rv32i_types;

  localparam int unsigned PREG_W = 6;
  localparam int unsigned NUM_FU = 5;

  typedef logic [PREG_W-1:0] preg_t;

  typedef enum logic [2:0] {
    FuAlu = 3'd0,
    FuMem = 3'd1,
    FuDiv = 3'd2,
    FuMul = 3'd3,
    FuBr  = 3'd4
  } fu_e;

endpackage

// File: rtl/prf_wr_arbiter.sv
// Combinational merge of the writeback ports into per-preg write strobes.
// Ports are scanned in ascending order so the highest port index wins when
// several ports target the same preg. Writes to preg 0 are dropped.
//   wr_en/wr_pd/wr_data : flattened writeback ports (port k at slice k)
//   we                  : per-preg write enable (bit 0 never set)
//   wdata               : per-preg winning write value
//   conflict            : two or more enabled ports hit the same nonzero preg
module prf_wr_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned PREG_W    = rv32i_types::PREG_W,
  parameter int unsigned NUM_PREGS = 64,
  parameter int unsigned NUM_WR    = 2
) (
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*PREG_W-1:0] wr_pd,
  input  logic [NUM_WR*32-1:0]     wr_data,
  output logic [NUM_PREGS-1:0]     we,
  output logic [31:0]              wdata [NUM_PREGS],
  output logic                     conflict
);

  always_comb begin
    logic [PREG_W-1:0] pd;
    we       = '0;
    conflict = 1'b0;
    pd       = '0;
    for (int p = 0; p < NUM_PREGS; p++) begin
      wdata[p] = '0;
    end
    for (int k = 0; k < NUM_WR; k++) begin
      pd = wr_pd[k*PREG_W +: PREG_W];
      if (wr_en[k] && (pd != '0)) begin
        // A second hit on an already-claimed preg is a conflict; later port overwrites.
        if (we[pd]) begin
          conflict = 1'b1;
        end
        we[pd]    = 1'b1;
        wdata[pd] = wr_data[k*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/prf_multiport.sv
// Physical register file with ready scoreboard for the OoO RV32I backend.
// Build option: define PRF_WR_BYPASS_EN to forward same-cycle writeback data
// (and ready) to the combinational read ports.
//   clk, rst_n      : clock, synchronous active-low reset
//   flush           : mispredict recovery, sets every ready bit
//   alloc_valid/pd  : rename allocation, clears ready of alloc_pd
//   wr_en/pd/data   : NUM_WR writeback ports (highest index wins)
//   rd_ps1/rd_ps2   : per-channel source indices
//   rd_v1/rd_v2     : per-channel source values (combinational)
//   rdy1/rdy2       : per-channel source ready (combinational)
//   wr_conflict     : registered same-preg multi-write flag
module prf_multiport
  import rv32i_types::*;
#(
  parameter int unsigned PREG_W    = rv32i_types::PREG_W,
  parameter int unsigned NUM_PREGS = 64,
  parameter int unsigned NUM_RD    = NUM_FU,
  parameter int unsigned NUM_WR    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     alloc_valid,
  input  logic [PREG_W-1:0]        alloc_pd,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*PREG_W-1:0] wr_pd,
  input  logic [NUM_WR*32-1:0]     wr_data,
  input  logic [NUM_RD*PREG_W-1:0] rd_ps1,
  input  logic [NUM_RD*PREG_W-1:0] rd_ps2,
  output logic [NUM_RD*32-1:0]     rd_v1,
  output logic [NUM_RD*32-1:0]     rd_v2,
  output logic [NUM_RD-1:0]        rdy1,
  output logic [NUM_RD-1:0]        rdy2,
  output logic                     wr_conflict
);

  logic [31:0]          data_q [NUM_PREGS];
  logic [NUM_PREGS-1:0] rdy_q, rdy_d;
  logic                 conflict_q;

  logic [NUM_PREGS-1:0] wr_we;
  logic [31:0]          wr_wdata [NUM_PREGS];
  logic                 wr_hit_conflict;

  prf_wr_arbiter #(
    .PREG_W    (PREG_W),
    .NUM_PREGS (NUM_PREGS),
    .NUM_WR    (NUM_WR)
  ) u_wr_arbiter (
    .wr_en    (wr_en),
    .wr_pd    (wr_pd),
    .wr_data  (wr_data),
    .we       (wr_we),
    .wdata    (wr_wdata),
    .conflict (wr_hit_conflict)
  );

  // Ready next state: writeback sets, allocation clears (and beats a same-cycle
  // write), flush sets everything and suppresses allocation.
  always_comb begin
    rdy_d = rdy_q | wr_we;
    if (flush) begin
      rdy_d = '1;
    end else if (alloc_valid && (alloc_pd != '0)) begin
      rdy_d[alloc_pd] = 1'b0;
    end
    rdy_d[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PREGS; p++) begin
        data_q[p] <= '0;
      end
      rdy_q      <= '1;
      conflict_q <= 1'b0;
    end else begin
      for (int p = 1; p < NUM_PREGS; p++) begin
        if (wr_we[p]) begin
          data_q[p] <= wr_wdata[p];
        end
      end
      rdy_q      <= rdy_d;
      conflict_q <= wr_hit_conflict;
    end
  end

  assign wr_conflict = conflict_q;

  always_comb begin
    logic [PREG_W-1:0] ps;
    rd_v1 = '0;
    rd_v2 = '0;
    rdy1  = '1;
    rdy2  = '1;
    ps    = '0;
    if (rst_n) begin
      for (int c = 0; c < NUM_RD; c++) begin
        ps = rd_ps1[c*PREG_W +: PREG_W];
        if (ps != '0) begin
          rd_v1[c*32 +: 32] = data_q[ps];
          rdy1[c]           = rdy_q[ps];
`ifdef PRF_WR_BYPASS_EN
          if (wr_we[ps]) begin
            rd_v1[c*32 +: 32] = wr_wdata[ps];
            rdy1[c]           = 1'b1;
          end
`endif
        end
        ps = rd_ps2[c*PREG_W +: PREG_W];
        if (ps != '0) begin
          rd_v2[c*32 +: 32] = data_q[ps];
          rdy2[c]           = rdy_q[ps];
`ifdef PRF_WR_BYPASS_EN
          if (wr_we[ps]) begin
            rd_v2[c*32 +: 32] = wr_wdata[ps];
            rdy2[c]           = 1'b1;
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_prf_multiport.sv
module tb_prf_multiport;
  import rv32i_types::*;

  localparam int unsigned PW = 6;
  localparam int unsigned NP = 64;
  localparam int unsigned NR = 5;
  localparam int unsigned NW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             alloc_valid;
  logic [PW-1:0]    alloc_pd;
  logic [NW-1:0]    wr_en;
  logic [NW*PW-1:0] wr_pd;
  logic [NW*32-1:0] wr_data;
  logic [NR*PW-1:0] rd_ps1, rd_ps2;
  logic [NR*32-1:0] rd_v1, rd_v2;
  logic [NR-1:0]    rdy1, rdy2;
  logic             wr_conflict;

  int passed = 0;
  int total  = 0;

  prf_multiport #(
    .PREG_W    (PW),
    .NUM_PREGS (NP),
    .NUM_RD    (NR),
    .NUM_WR    (NW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .alloc_valid (alloc_valid),
    .alloc_pd    (alloc_pd),
    .wr_en       (wr_en),
    .wr_pd       (wr_pd),
    .wr_data     (wr_data),
    .rd_ps1      (rd_ps1),
    .rd_ps2      (rd_ps2),
    .rd_v1       (rd_v1),
    .rd_v2       (rd_v2),
    .rdy1        (rdy1),
    .rdy2        (rdy2),
    .wr_conflict (wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled 4 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic set_all(input logic [PW-1:0] p1, input logic [PW-1:0] p2);
    for (int c = 0; c < NR; c++) begin
      rd_ps1[c*PW +: PW] = p1;
      rd_ps2[c*PW +: PW] = p2;
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; alloc_valid = 1'b0; alloc_pd = '0;
    wr_en = '0; wr_pd = '0; wr_data = '0;
    set_all(6'd12, 6'd7);

    // Reset held for two edges
    tick();
    tick();
    settle();
    check("in_reset_v1", rd_v1[31:0], 32'h0);
    check("in_reset_rdy1", {27'b0, rdy1}, 32'h1f);
    rst_n = 1'b1;
    settle();
    check("post_reset_conflict", {31'b0, wr_conflict}, 32'h0);
    for (int p = 0; p < NP; p++) begin
      set_all(p[PW-1:0], p[PW-1:0]);
      #1;
      check($sformatf("reset_v1_p%0d", p), rd_v1[p%NR*32 +: 32], 32'h0);
      check($sformatf("reset_v2_p%0d", p), rd_v2[(p+1)%NR*32 +: 32], 32'h0);
      check($sformatf("reset_rdy1_p%0d", p), {27'b0, rdy1}, 32'h1f);
      check($sformatf("reset_rdy2_p%0d", p), {27'b0, rdy2}, 32'h1f);
    end

    // Allocate preg 12, then write it back from port 1
    tick();
    alloc_valid = 1'b1; alloc_pd = 6'd12;
    set_all(6'd0, 6'd0);
    rd_ps1[int'(FuAlu)*PW +: PW] = 6'd12;
    tick();
    alloc_valid = 1'b0; alloc_pd = '0;
    settle();
    check("alloc12_rdy_alu", {31'b0, rdy1[int'(FuAlu)]}, 32'h0);
    check("alloc12_other_ch_rdy", {28'b0, rdy1[4:1]}, 32'hf);
    tick();
    tick();
    wr_en = 2'b10; wr_pd = {6'd12, 6'd0}; wr_data = {32'hDEADBEEF, 32'h0};
    settle();
`ifdef PRF_WR_BYPASS_EN
    check("wb12_same_cycle_v", rd_v1[int'(FuAlu)*32 +: 32], 32'hDEADBEEF);
    check("wb12_same_cycle_rdy", {31'b0, rdy1[int'(FuAlu)]}, 32'h1);
`else
    check("wb12_same_cycle_v", rd_v1[int'(FuAlu)*32 +: 32], 32'h0);
    check("wb12_same_cycle_rdy", {31'b0, rdy1[int'(FuAlu)]}, 32'h0);
`endif
    tick();
    wr_en = '0; wr_pd = '0; wr_data = '0;
    set_all(6'd12, 6'd12);
    settle();
    for (int c = 0; c < NR; c++) begin
      check($sformatf("wb12_v1_ch%0d", c), rd_v1[c*32 +: 32], 32'hDEADBEEF);
      check($sformatf("wb12_v2_ch%0d", c), rd_v2[c*32 +: 32], 32'hDEADBEEF);
    end
    check("wb12_rdy1", {27'b0, rdy1}, 32'h1f);

    // Both ports hit preg 7: port 1 wins, conflict for one cycle
    tick();
    wr_en = 2'b11; wr_pd = {6'd7, 6'd7}; wr_data = {32'h22, 32'h11};
    set_all(6'd7, 6'd7);
    settle();
    check("conflict_before_edge", {31'b0, wr_conflict}, 32'h0);
    tick();
    wr_en = '0; wr_pd = '0; wr_data = '0;
    settle();
    check("conflict_set", {31'b0, wr_conflict}, 32'h1);
    check("conflict_winner_v", rd_v1[int'(FuDiv)*32 +: 32], 32'h22);
    tick();
    settle();
    check("conflict_cleared", {31'b0, wr_conflict}, 32'h0);
    check("conflict_winner_kept", rd_v2[int'(FuBr)*32 +: 32], 32'h22);

    // Preg 0: writes and allocation ignored, no conflict
    tick();
    wr_en = 2'b11; wr_pd = {6'd0, 6'd0}; wr_data = {32'h55, 32'h55};
    alloc_valid = 1'b1; alloc_pd = 6'd0;
    set_all(6'd0, 6'd0);
    settle();
    check("p0_same_cycle_v", rd_v1[0 +: 32], 32'h0);
    tick();
    wr_en = '0; wr_pd = '0; wr_data = '0; alloc_valid = 1'b0;
    settle();
    check("p0_v1", rd_v1[int'(FuMem)*32 +: 32], 32'h0);
    check("p0_rdy1", {27'b0, rdy1}, 32'h1f);
    check("p0_no_conflict", {31'b0, wr_conflict}, 32'h0);

    // Same-cycle write to preg 30 read on the mul channel
    tick();
    wr_en = 2'b01; wr_pd = {6'd0, 6'd30}; wr_data = {32'h0, 32'hA5A5};
    set_all(6'd0, 6'd0);
    rd_ps2[int'(FuMul)*PW +: PW] = 6'd30;
    settle();
`ifdef PRF_WR_BYPASS_EN
    check("byp30_same_v", rd_v2[int'(FuMul)*32 +: 32], 32'hA5A5);
`else
    check("byp30_same_v", rd_v2[int'(FuMul)*32 +: 32], 32'h0);
`endif
    check("byp30_same_rdy", {31'b0, rdy2[int'(FuMul)]}, 32'h1);
    tick();
    wr_en = '0; wr_pd = '0; wr_data = '0;
    settle();
    check("byp30_next_v", rd_v2[int'(FuMul)*32 +: 32], 32'hA5A5);

    // Allocate 3,4,5 then flush with a same-cycle allocation of 9
    tick();
    alloc_valid = 1'b1; alloc_pd = 6'd3;
    tick();
    alloc_pd = 6'd4;
    tick();
    alloc_pd = 6'd5;
    tick();
    alloc_valid = 1'b0;
    set_all(6'd0, 6'd0);
    rd_ps1[0*PW +: PW] = 6'd3;
    rd_ps1[1*PW +: PW] = 6'd4;
    rd_ps1[2*PW +: PW] = 6'd5;
    rd_ps1[3*PW +: PW] = 6'd9;
    rd_ps1[4*PW +: PW] = 6'd12;
    settle();
    check("alloc345_rdy1", {27'b0, rdy1}, 32'h18);
    tick();
    flush = 1'b1; alloc_valid = 1'b1; alloc_pd = 6'd9;
    tick();
    flush = 1'b0; alloc_valid = 1'b0; alloc_pd = '0;
    settle();
    check("flush_rdy1", {27'b0, rdy1}, 32'h1f);
    check("flush_keeps_data", rd_v1[4*32 +: 32], 32'hDEADBEEF);

    // Allocate and write preg 40 in one cycle: allocation wins the ready bit
    tick();
    alloc_valid = 1'b1; alloc_pd = 6'd40;
    wr_en = 2'b01; wr_pd = {6'd0, 6'd40}; wr_data = {32'h0, 32'h7};
    set_all(6'd40, 6'd40);
    settle();
`ifdef PRF_WR_BYPASS_EN
    check("aw40_same_v", rd_v1[0 +: 32], 32'h7);
`else
    check("aw40_same_v", rd_v1[0 +: 32], 32'h0);
`endif
    check("aw40_same_rdy", {31'b0, rdy1[0]}, 32'h1);
    tick();
    alloc_valid = 1'b0; wr_en = '0; wr_pd = '0; wr_data = '0;
    settle();
    check("aw40_rdy", {27'b0, rdy1}, 32'h0);
    check("aw40_v", rd_v2[2*32 +: 32], 32'h7);

    // Reset beats a same-cycle flush and write; data array cleared
    tick();
    rst_n = 1'b0; flush = 1'b1;
    wr_en = 2'b01; wr_pd = {6'd0, 6'd40}; wr_data = {32'h0, 32'h99};
    settle();
    check("rst_gate_v", rd_v1[0 +: 32], 32'h0);
    check("rst_gate_rdy", {27'b0, rdy1}, 32'h1f);
    tick();
    rst_n = 1'b1; flush = 1'b0; wr_en = '0; wr_pd = '0; wr_data = '0;
    settle();
    check("rst_clears_40", rd_v1[0 +: 32], 32'h0);
    check("rst_sets_rdy", {27'b0, rdy1}, 32'h1f);
    set_all(6'd12, 6'd7);
    #1;
    check("rst_clears_12", rd_v1[0 +: 32], 32'h0);
    check("rst_clears_7", rd_v2[0 +: 32], 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
